// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer for a MIPS-like datapath
// with memory-wait timeout, a sticky illegal-opcode flag and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int ALUOP_W = 3,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         instr_op,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               branch,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         state,
    output logic               illegal,
    output logic               error,
    output logic [CNT_W-1:0]   retired
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b010000;
    localparam logic [5:0] OP_SUBI = 6'b010001;
    localparam logic [5:0] OP_ANDI = 6'b010010;
    localparam logic [5:0] OP_BEQ  = 6'b001000;
    localparam logic [5:0] OP_BNE  = 6'b001001;
    localparam logic [5:0] OP_BGT  = 6'b001010;
    localparam logic [5:0] OP_BGE  = 6'b001011;
    localparam logic [5:0] OP_BLE  = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000001;
    localparam logic [5:0] OP_JAL  = 6'b000010;
    localparam logic [5:0] OP_JR   = 6'b000011;

    localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] RET_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [2:0] alu_code(input logic [5:0] op);
        logic [2:0] code;
        case (op)
            OP_R:            code = 3'b010;
            OP_SUBI, OP_BEQ: code = 3'b001;
            OP_ANDI:         code = 3'b011;
            OP_BNE:          code = 3'b100;
            OP_BGT:          code = 3'b101;
            OP_BGE:          code = 3'b110;
            OP_BLE:          code = 3'b111;
            default:         code = 3'b000;
        endcase
        return code;
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_ADDI, OP_SUBI, OP_ANDI, OP_BEQ, OP_BNE, OP_BGT,
                          OP_BGE, OP_BLE, OP_LW, OP_SW, OP_J, OP_JAL, OP_JR};
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLE};
    endfunction

    function automatic logic is_imm(input logic [5:0] op);
        return op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_LW, OP_SW};
    endfunction

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [7:0]       wait_q, wait_d;
    logic [7:0]       wait_inc;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;

    // Next-state, bookkeeping and output decode from state and latched opcode
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_d     = 8'd0;
        retired_d  = retired_q;
        illegal_d  = illegal_q;
        wait_inc   = wait_q + 8'd1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        branch     = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        alu_op     = {ALUOP_W{1'b0}};
        error      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = 2'd0;
                    op_d     = instr_op;
                    state_d  = S_DECODE;
                end else if (wait_inc == TIMEOUT_C) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                if (!is_legal(op_q)) begin
                    illegal_d = 1'b1;
                    state_d   = S_FETCH;
                end else if (op_q == OP_J || op_q == OP_JAL) begin
                    pc_write  = 1'b1;
                    pc_src    = 2'd2;
                    reg_write = (op_q == OP_JAL);
                    reg_dst   = (op_q == OP_JAL) ? 2'd2 : 2'd0;
                    state_d   = S_FETCH;
                    retired_d = retired_q + RET_ONE;
                end else if (op_q == OP_JR) begin
                    pc_write  = 1'b1;
                    pc_src    = 2'd3;
                    state_d   = S_FETCH;
                    retired_d = retired_q + RET_ONE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op  = ALUOP_W'(alu_code(op_q));
                alu_src = is_imm(op_q);
                if (is_branch(op_q)) begin
                    branch    = 1'b1;
                    pc_src    = 2'd1;
                    state_d   = S_FETCH;
                    retired_d = retired_q + RET_ONE;
                end else if (op_q == OP_LW || op_q == OP_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_src   = 1'b1;
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        state_d   = S_FETCH;
                        retired_d = retired_q + RET_ONE;
                    end
                end else if (wait_inc == TIMEOUT_C) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_WB: begin
                // ALU controls stay at their EXEC values so the result remains stable
                alu_op     = ALUOP_W'(alu_code(op_q));
                alu_src    = is_imm(op_q);
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_R) ? 2'd1 : 2'd0;
                mem_to_reg = (op_q == OP_LW);
                state_d    = S_FETCH;
                retired_d  = retired_q + RET_ONE;
            end
            S_ERR: begin
                error   = 1'b1;
                state_d = S_ERR;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State, opcode latch, wait counter, retire counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            wait_q    <= 8'd0;
            retired_q <= {CNT_W{1'b0}};
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): ALUOP_W, 3, alu_op width (>=3; codes zero-extended); TIMEOUT, 15, max wait cycles for mem_ready (1..255); CNT_W, 16, retired-instruction counter width.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- instr_op, in, 6, opcode field of the memory read data.
- mem_ready, in, 1, memory completed the current access this cycle.
- mem_read / mem_write, out, 1, memory access request.
- ir_write / pc_write, out, 1, instruction-register and PC load strobes.
- pc_src, out, 2, 0 = PC+4, 1 = branch target (gated by the datapath compare), 2 = jump target, 3 = rs (JR).
- branch, mem_to_reg, alu_src, reg_write, out, 1, datapath controls.
- reg_dst, out, 2, 0 = rt, 1 = rd, 2 = r31.
- alu_op, out, ALUOP_W, ALU operation.
- state, out, 3, current FSM state.
- illegal, out, 1, sticky flag for an undefined opcode.
- error, out, 1, memory timeout occurred.
- retired, out, CNT_W, count of completed instructions.

Function
REQ-004 The opcode encodings SHALL be: R 000000, ADDI 010000, SUBI 010001, ANDI 010010, BEQ 001000, BNE 001001, BGT 001010, BGE 001011, BLE 001100, LW 100011, SW 101011, J 000001, JAL 000010, JR 000011. All other opcodes are illegal.
REQ-005 The FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5. The unused codes 6 and 7 SHALL go to FETCH on the next clock.
REQ-006 All outputs SHALL be combinational from the state and the latched opcode op_q. Any strobe not listed for a state SHALL be 0.
REQ-007 FETCH: mem_read=1.
- On mem_ready: ir_write=1, pc_write=1, pc_src=0, op_q<=instr_op, next state DECODE.
- Otherwise: stay in FETCH.
REQ-008 DECODE, by op_q:
- Illegal: set illegal, next state FETCH, no strobes, retired unchanged.
- J: pc_write=1, pc_src=2, next state FETCH.
- JAL: the J outputs plus reg_write=1 and reg_dst=2.
- JR: pc_write=1, pc_src=3, next state FETCH.
- All other opcodes: next state EXEC.
REQ-009 EXEC, alu_op values:
- R 010, ADDI/LW/SW 000, SUBI/BEQ 001, ANDI 011, BNE 100, BGT 101, BGE 110, BLE 111.
- alu_src=1 for ADDI, SUBI, ANDI, LW and SW.
- Branches: branch=1, pc_src=1, next state FETCH.
- LW/SW: next state MEM.
- R/ADDI/SUBI/ANDI: next state WB.
REQ-010 MEM: alu_op=000 and alu_src=1 held.
- LW: mem_read=1; on mem_ready, next state WB.
- SW: mem_write=1; on mem_ready, next state FETCH.
REQ-011 WB: reg_write=1; reg_dst=1 for R, otherwise 0; mem_to_reg=1 for LW only; next state FETCH. alu_op and alu_src SHALL hold their EXEC values.
REQ-012 The wait counter SHALL clear on every state change and on mem_ready. It SHALL increment each FETCH/MEM cycle without mem_ready. The cycle in which it would reach TIMEOUT SHALL go to ERR. mem_ready on that same cycle SHALL win.
REQ-013 ERR: error=1, all strobes 0, FSM held in ERR until rst.
REQ-014 retired SHALL increment by 1 on every legal transition into FETCH (from DECODE, EXEC, MEM or WB), wrapping modulo 2^CNT_W.
REQ-015 illegal SHALL remain 1 until rst, and execution SHALL continue.

Reset
REQ-016 While rst=1 at a clock edge, the next values SHALL be: state=FETCH, op_q=0, wait counter=0, retired=0, illegal=0, error=0.
REQ-017 Reset SHALL abort any state, including MEM mid-wait and ERR, with no pending access retained.
REQ-018 During the reset cycle the outputs SHALL reflect the current state. After reset they SHALL show FETCH values (mem_read=1).

Verification
REQ-019 The bench SHALL cover these scenarios:
- ADDI with mem_ready=1 every cycle: FETCH,DECODE,EXEC,WB = 4 cycles; WB shows reg_write=1, alu_src=1, alu_op=000; retired=1.
- LW with mem_ready withheld 3 cycles in MEM: 8 cycles total; WB shows mem_to_reg=1, reg_dst=0.
- JAL: 2 cycles; DECODE shows pc_src=2, reg_dst=2, reg_write=1, pc_write=1.
- Opcode 111111: illegal=1 after DECODE, next fetch proceeds, retired unchanged.
- FETCH with mem_ready low for 15 cycles (TIMEOUT=15): state=ERR, error=1. A later rst returns state=0 and error=0.
- CNT_W=2, five ADDI instructions: retired reads 1,2,3,0,1.
